// File: rtl/dmem_arbiter_if.sv
// Bundles both requester ports and the data-memory bus of dmem_arbiter.
// Latency: none, wiring only.
// Backpressure: a requester holds req with a stable command until its ack.
//
// master: the arbiter's view. It receives the requests and mem_rdata, and
//         drives the acks, the response data, the memory command and busy.
// slave : the view of the requesters and the memory model.
interface dmem_arbiter_if;
    logic        p0_req;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic [1:0]  p0_we;
    logic [2:0]  p0_re;
    logic        p0_ack;
    logic        p0_err;
    logic [31:0] p0_rdata;

    logic        p1_req;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic [1:0]  p1_we;
    logic [2:0]  p1_re;
    logic        p1_ack;
    logic        p1_err;
    logic [31:0] p1_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_we;
    logic [2:0]  mem_re;
    logic [31:0] mem_rdata;

    logic        busy;

    modport master (
        input  p0_req, p0_addr, p0_wdata, p0_we, p0_re,
        output p0_ack, p0_err, p0_rdata,
        input  p1_req, p1_addr, p1_wdata, p1_we, p1_re,
        output p1_ack, p1_err, p1_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata,
        output busy
    );

    modport slave (
        output p0_req, p0_addr, p0_wdata, p0_we, p0_re,
        input  p0_ack, p0_err, p0_rdata,
        output p1_req, p1_addr, p1_wdata, p1_we, p1_re,
        input  p1_ack, p1_err, p1_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and sequencer in front of the byte-addressed data memory.
// Latency: a valid access acks two cycles after the grant edge; a rejected command acks one cycle after it.
// Backpressure: a losing requester holds req and is neither sampled nor acked until it is granted.
//
// Ports: clk, reset (async active-low), bus (dmem_arbiter_if.master).
// bus carries the p0/p1 req/addr/wdata/we/re, ack/err/rdata, the mem_* command and read data, and busy.
module dmem_arbiter #(
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.master bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  state;
    logic        last_grant;
    logic        gnt_id;

    // Candidate winner, selected combinationally from the live requests in IDLE.
    logic        sel1;
    logic        any_req;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_we;
    logic [2:0]  req_re;
    logic [2:0]  size;
    logic        align_ok;
    logic        range_ok;
    logic        cmd_ok;

    // On contention, the port that did not win last time gets the grant.
    assign any_req   = bus.p0_req | bus.p1_req;
    assign sel1      = bus.p1_req & (~bus.p0_req | ~last_grant);
    assign req_addr  = sel1 ? bus.p1_addr  : bus.p0_addr;
    assign req_wdata = sel1 ? bus.p1_wdata : bus.p0_wdata;
    assign req_we    = sel1 ? bus.p1_we    : bus.p0_we;
    assign req_re    = sel1 ? bus.p1_re    : bus.p0_re;

    always_comb begin
        size = 3'd0;
        if (req_we != 2'd0) begin
            case (req_we)
                2'd1:    size = 3'd1;
                2'd2:    size = 3'd2;
                2'd3:    size = 3'd4;
                default: size = 3'd0;
            endcase
        end else begin
            case (req_re)
                3'd1, 3'd4: size = 3'd1;
                3'd2, 3'd5: size = 3'd2;
                3'd3:       size = 3'd4;
                default:    size = 3'd0;
            endcase
        end
    end

    assign align_ok = !((size == 3'd2) && req_addr[0]) &&
                      !((size == 3'd4) && (req_addr[1:0] != 2'b00));
    // The sum is widened to 33 bits so an address near 2^32 cannot wrap into range.
    assign range_ok = (({1'b0, req_addr} + 33'(size)) <= 33'(DEPTH));
    assign cmd_ok   = ((req_we != 2'd0) ^ (req_re != 3'd0)) && (req_re < 3'd6) &&
                      (size != 3'd0) && align_ok && range_ok;

    assign bus.busy = (state != IDLE);

    // The mem_* registers double as the latched command. mem_we/mem_re are
    // only nonzero during ACCESS; mem_addr/mem_wdata keep their last values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            gnt_id        <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
            bus.mem_we    <= 2'd0;
            bus.mem_re    <= 3'd0;
            bus.p0_ack    <= 1'b0;
            bus.p0_err    <= 1'b0;
            bus.p0_rdata  <= 32'd0;
            bus.p1_ack    <= 1'b0;
            bus.p1_err    <= 1'b0;
            bus.p1_rdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_id <= sel1;
                        if (cmd_ok) begin
                            bus.mem_addr  <= req_addr;
                            bus.mem_wdata <= req_wdata;
                            bus.mem_we    <= req_we;
                            bus.mem_re    <= req_re;
                            state         <= ACCESS;
                        end else begin
                            // Rejected: skip memory entirely and respond next cycle.
                            if (sel1) begin
                                bus.p1_ack   <= 1'b1;
                                bus.p1_err   <= 1'b1;
                                bus.p1_rdata <= 32'd0;
                            end else begin
                                bus.p0_ack   <= 1'b1;
                                bus.p0_err   <= 1'b1;
                                bus.p0_rdata <= 32'd0;
                            end
                            state <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    bus.mem_we <= 2'd0;
                    bus.mem_re <= 3'd0;
                    if (gnt_id) begin
                        bus.p1_ack   <= 1'b1;
                        bus.p1_err   <= 1'b0;
                        bus.p1_rdata <= (bus.mem_re != 3'd0) ? bus.mem_rdata : 32'd0;
                    end else begin
                        bus.p0_ack   <= 1'b1;
                        bus.p0_err   <= 1'b0;
                        bus.p0_rdata <= (bus.mem_re != 3'd0) ? bus.mem_rdata : 32'd0;
                    end
                    state <= RESP;
                end
                RESP: begin
                    bus.p0_ack <= 1'b0;
                    bus.p0_err <= 1'b0;
                    bus.p1_ack <= 1'b0;
                    bus.p1_err <= 1'b0;
                    last_grant <= gnt_id;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
